// File: rtl/dac_channel_sequencer.sv
// rtl/dac_channel_sequencer.sv - per-channel DAC code table and analog mux sequencer feeding the DAC serial driver
//
// Steps the mux through channels 0..NUM_CH-1. For each channel it waits out mux settling,
// presents the stored code to the driver with a valid/ready handshake, waits for the driver's
// load-complete pulse, then dwells before advancing.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   enable          - level; 1 runs the sequence, 0 stops at a safe point
//   wr_en/addr/data - table write port (addresses >= NUM_CH ignored)
//   sample_data/valid, sample_ready - code handshake towards the driver
//   dac_done        - one-cycle load-complete pulse from the driver
//   mux_sel         - analog mux channel select
//   busy            - high whenever the sequencer is not idle
//   wrap            - one-cycle pulse when the channel index returns from NUM_CH-1 to 0
module dac_channel_sequencer #(
   parameter int NUM_CH     = 8,
   parameter int SETTLE_CYC = 16,
   parameter int DWELL_CYC  = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [5:0]  wr_addr,
   input  logic [11:0] wr_data,
   output logic [11:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   input  logic        dac_done,
   output logic [5:0]  mux_sel,
   output logic        busy,
   output logic        wrap
);

   localparam int AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYC - 1);
   localparam logic [5:0]    LAST_CH     = 6'(NUM_CH - 1);
   localparam logic [6:0]    NUM_CH_W    = 7'(NUM_CH);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      PRESENT,
      WAIT_DONE,
      DWELL
   } state_t;

   state_t         state_q, state_d;
   logic [5:0]     ch_q, ch_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [11:0]    data_q, data_d;
   logic           wrap_q, wrap_d;
   logic [11:0]    table_q [NUM_CH];

   // Table write port; out-of-range addresses are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            table_q[i] <= '0;
         end
      end else if (wr_en && ({1'b0, wr_addr} < NUM_CH_W)) begin
         table_q[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      wrap_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               ch_d    = '0;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end

         SETTLE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               // Registered table read: a write landing on this same edge is not seen.
               data_d  = table_q[ch_q[AW-1:0]];
               state_d = PRESENT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // enable is deliberately ignored here and in WAIT_DONE so the driver never
         // sees a withdrawn valid or an unacknowledged load.
         PRESENT: begin
            if (sample_ready) begin
               state_d = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (dac_done) begin
               cnt_d   = '0;
               state_d = DWELL;
            end
         end

         DWELL: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (cnt_q == DWELL_LAST) begin
               ch_d    = (ch_q == LAST_CH) ? 6'd0 : ch_q + 6'd1;
               wrap_d  = (ch_q == LAST_CH);
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sample_data  = data_q;
   assign sample_valid = (state_q == PRESENT);
   assign mux_sel      = ch_q;
   assign busy         = (state_q != IDLE);
   assign wrap         = wrap_q;

endmodule

// File: tb/tb_dac_channel_sequencer.sv
// tb/tb_dac_channel_sequencer.sv - directed self-checking bench for dac_channel_sequencer
module tb_dac_channel_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        wr_en = 1'b0;
   logic [5:0]  wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic [11:0] sample_data;
   logic        sample_valid;
   logic        sample_ready = 1'b0;
   logic        dac_done = 1'b0;
   logic [5:0]  mux_sel;
   logic        busy;
   logic        wrap;

   int tests = 0;
   int fails = 0;

   // Driver model and timing trackers, maintained by step().
   bit         auto_done = 1'b0;
   int         hs_pend = 0;
   int         cyc = 0;
   int         mux_chg_cyc = 0;
   int         wrap_cyc = 0;
   int         wrap_count = 0;
   logic [5:0] prev_mux = '0;

   dac_channel_sequencer #(
      .NUM_CH     (4),
      .SETTLE_CYC (3),
      .DWELL_CYC  (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .dac_done     (dac_done),
      .mux_sel      (mux_sel),
      .busy         (busy),
      .wrap         (wrap)
   );

   always #5 clk = ~clk;

   // Advance one cycle to the next negedge. A handshake seen at entry raises dac_done
   // for one cycle, four cycles later.
   task automatic step();
      if (auto_done && sample_valid === 1'b1 && sample_ready && hs_pend == 0) hs_pend = 4;
      @(negedge clk);
      dac_done = 1'b0;
      if (hs_pend > 0) begin
         hs_pend--;
         if (hs_pend == 0) dac_done = 1'b1;
      end
      cyc++;
      if (mux_sel !== prev_mux) begin
         mux_chg_cyc = cyc;
         prev_mux    = mux_sel;
      end
      if (wrap === 1'b1) begin
         wrap_count++;
         wrap_cyc = cyc;
      end
   endtask

   task automatic wait_valid(output bit ok);
      int k;
      k = 0;
      while (sample_valid !== 1'b1 && k < 64) begin
         step();
         k++;
      end
      ok = (sample_valid === 1'b1);
   endtask

   task automatic tb_write(input logic [5:0] a, input logic [11:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b exp 0", wrap); end
      tests++; if (mux_sel !== 6'd0) begin fails++; $display("FAIL reset_mux got %0d exp 0", mux_sel); end
      tests++; if (sample_data !== 12'h000) begin fails++; $display("FAIL reset_data got %h exp 000", sample_data); end
   endtask

   task automatic test_sequence();
      logic [11:0] exp_data [5];
      logic [5:0]  exp_mux  [5];
      int last_valid_cyc;
      bit ok;
      exp_data = '{12'h000, 12'h555, 12'hAAA, 12'hFFF, 12'h000};
      exp_mux  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0};
      tb_write(6'd0, 12'h000);
      tb_write(6'd1, 12'h555);
      tb_write(6'd2, 12'hAAA);
      tb_write(6'd3, 12'hFFF);
      wrap_count     = 0;
      last_valid_cyc = 0;
      sample_ready   = 1'b1;
      auto_done      = 1'b1;
      enable         = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_valid(ok);
         tests++; if (!ok) begin fails++; $display("FAIL seq_timeout%0d got valid=%b exp 1", i, sample_valid); end
         tests++; if (sample_data !== exp_data[i]) begin fails++; $display("FAIL seq_data%0d got %h exp %h", i, sample_data, exp_data[i]); end
         tests++; if (mux_sel !== exp_mux[i]) begin fails++; $display("FAIL seq_mux%0d got %0d exp %0d", i, mux_sel, exp_mux[i]); end
         if (i > 0) begin
            tests++; if (cyc - mux_chg_cyc != 3) begin fails++; $display("FAIL seq_settle%0d got %0d exp 3", i, cyc - mux_chg_cyc); end
            tests++; if (cyc - last_valid_cyc != 13) begin fails++; $display("FAIL seq_period%0d got %0d exp 13", i, cyc - last_valid_cyc); end
         end
         last_valid_cyc = cyc;
         step();
      end
      tests++; if (wrap_count != 1) begin fails++; $display("FAIL seq_wrap_count got %0d exp 1", wrap_count); end
      tests++; if (wrap_cyc != mux_chg_cyc) begin fails++; $display("FAIL seq_wrap_time got %0d exp %0d", wrap_cyc, mux_chg_cyc); end
   endtask

   task automatic test_ready_hold();
      int held;
      bit ok;
      sample_ready = 1'b0;
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL hold_timeout got valid=%b exp 1", sample_valid); end
      held = 0;
      for (int k = 0; k < 10; k++) begin
         if (sample_valid === 1'b1 && sample_data === 12'h555) held++;
         if (k < 9) step();
      end
      tests++; if (held != 10) begin fails++; $display("FAIL hold_stable got %0d cycles exp 10", held); end
      sample_ready = 1'b1;
      step();
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL hold_after_hs got %b exp 0", sample_valid); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_busy got %b exp 1", busy); end
   endtask

   task automatic test_disable_dwell();
      int k;
      int zeros;
      k = 0;
      while (dac_done !== 1'b1 && k < 32) begin
         step();
         k++;
      end
      tests++; if (dac_done !== 1'b1) begin fails++; $display("FAIL dwell_done_timeout got %b exp 1", dac_done); end
      step();
      enable = 1'b0;
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL dwell_abort_busy got %b exp 0", busy); end
      tests++; if (mux_sel !== 6'd1) begin fails++; $display("FAIL dwell_mux_hold got %0d exp 1", mux_sel); end
      step();
      enable = 1'b1;
      step();
      tests++; if (mux_sel !== 6'd0) begin fails++; $display("FAIL restart_mux got %0d exp 0", mux_sel); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy got %b exp 1", busy); end
      zeros = 0;
      while (sample_valid !== 1'b1 && zeros < 10) begin
         zeros++;
         step();
      end
      tests++; if (zeros != 3) begin fails++; $display("FAIL restart_settle got %0d exp 3", zeros); end
      tests++; if (sample_data !== 12'h000) begin fails++; $display("FAIL restart_data got %h exp 000", sample_data); end
   endtask

   task automatic test_disable_wait_done();
      int k;
      int vcount;
      step();
      enable = 1'b0;
      k = 0;
      while (dac_done !== 1'b1 && k < 32) begin
         step();
         k++;
      end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wd_busy_until_done got %b exp 1", busy); end
      step();
      step();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_idle got %b exp 0", busy); end
      vcount = 0;
      for (int n = 0; n < 20; n++) begin
         if (sample_valid === 1'b1) vcount++;
         step();
      end
      tests++; if (vcount != 0) begin fails++; $display("FAIL wd_no_valid got %0d exp 0", vcount); end
      tests++; if (mux_sel !== 6'd0) begin fails++; $display("FAIL wd_mux_hold got %0d exp 0", mux_sel); end
   endtask

   task automatic test_write_rules();
      logic [11:0] exp_data [5];
      bit ok;
      exp_data = '{12'h000, 12'h555, 12'hAAA, 12'hFFF, 12'h7FF};
      tb_write(6'd9, 12'h123);
      enable = 1'b1;
      step();
      step();
      step();
      wr_en   = 1'b1;
      wr_addr = 6'd0;
      wr_data = 12'h7FF;
      step();
      wr_en   = 1'b0;
      tests++; if (sample_valid !== 1'b1) begin fails++; $display("FAIL latch_valid got %b exp 1", sample_valid); end
      tests++; if (sample_data !== 12'h000) begin fails++; $display("FAIL latch_old_data got %h exp 000", sample_data); end
      step();
      for (int i = 1; i < 5; i++) begin
         wait_valid(ok);
         tests++; if (!ok || sample_data !== exp_data[i]) begin fails++; $display("FAIL wr_lap_data%0d got %h exp %h", i, sample_data, exp_data[i]); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      sample_ready = 1'b0;
      wait_valid(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rst_mid_timeout got valid=%b exp 1", sample_valid); end
      reset = 1'b1;
      step();
      tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b exp 0", sample_valid); end
      tests++; if (mux_sel !== 6'd0) begin fails++; $display("FAIL rst_mid_mux got %0d exp 0", mux_sel); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      reset        = 1'b0;
      hs_pend      = 0;
      dac_done     = 1'b0;
      sample_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_valid(ok);
         tests++; if (!ok || sample_data !== 12'h000) begin fails++; $display("FAIL rst_clear_data%0d got %h exp 000", i, sample_data); end
         tests++; if (mux_sel !== 6'(i)) begin fails++; $display("FAIL rst_clear_mux%0d got %0d exp %0d", i, mux_sel, i); end
         step();
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_ready_hold();
      test_disable_dwell();
      test_disable_wait_done();
      test_write_rules();
      test_reset_mid();
      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
